// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer
// Time-multiplexes one external CHUNK-bit carry-lookahead slice across a WIDTH-bit add.
// The operands are latched on accept. They are fed to the slice one chunk per clock,
// starting with the least significant chunk. The slice carry-out is registered and fed
// back as the carry-in of the next chunk.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// A source holds valid and its data stable until that edge. Ready never depends
// combinationally on valid.
//
// Optional feature: define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_chunk_sequencer #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] slice_a,
    output logic [CHUNK-1:0] slice_b,
    output logic             slice_cin,
    input  logic [CHUNK-1:0] slice_s,
    input  logic             slice_g,
    input  logic             slice_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // IDLE waits for operands, RUN walks the chunks, DONE presents the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // state is left as a plain named signal so checkers can bind to it directly.
    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_hold;
    logic [WIDTH-1:0]   b_hold;
    logic               carry;
    logic [WIDTH-1:0]   sum_acc;
    logic               c_out_acc;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic               carry_next;
    logic               last_chunk;

    // Select the current chunk of each held operand for the shared slice.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                chunk_a = a_hold[i*CHUNK +: CHUNK];
                chunk_b = b_hold[i*CHUNK +: CHUNK];
            end
        end
    end

    // Carry out of the current chunk comes from the group generate/propagate terms.
    always_comb begin
        carry_next = slice_g | (slice_p & carry);
        last_chunk = (idx == LAST_IDX);
    end

    assign slice_a   = chunk_a;
    assign slice_b   = chunk_b;
    assign slice_cin = carry;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_acc;
    assign c_out     = c_out_acc;

    // Sequencer FSM. The handshake outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            a_hold      <= '0;
            b_hold      <= '0;
            carry       <= 1'b0;
            sum_acc     <= '0;
            c_out_acc   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_hold     <= a;
                        b_hold     <= b;
                        carry      <= c_in;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum_acc[i*CHUNK +: CHUNK] <= slice_s;
                        end
                    end
                    carry <= carry_next;
                    if (last_chunk) begin
                        c_out_acc   <= carry_next;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE raises in_ready one cycle after the result
                    // handshake. A new operand set cannot be accepted in the same cycle.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CLA_SEQ_OVF_EN
    logic ovf_r;
    logic carry_into_msb;

    // Recover the carry into the MSB from its sum bit: s = a ^ b ^ cin.
    always_comb begin
        carry_into_msb = slice_s[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
    end

    // Signed overflow is captured on the last chunk, together with c_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state == ST_RUN && last_chunk) begin
            ovf_r <= carry_into_msb ^ carry_next;
        end
    end

    assign ovf = ovf_r;
`else
    // Without the overflow option, no extra state is kept.
`endif

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// tb_cla_chunk_sequencer
// Drives cla_chunk_sequencer through a behavioural CHUNK-bit slice model.
// Results are compared against a whole-word arithmetic reference held in a scoreboard queue.
// Define CLA_SEQ_OVF_EN to also check the overflow output.
module tb_cla_chunk_sequencer;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;
    localparam int EW    = WIDTH + 2;   // {ovf, c_out, sum}

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic             slice_cin;
    logic [CHUNK-1:0] slice_s;
    logic             slice_g;
    logic             slice_p;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;
`endif

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    cla_chunk_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_s   (slice_s),
        .slice_g   (slice_g),
        .slice_p   (slice_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- behavioural CLA slice ----------------
    logic [CHUNK:0] gen_tot;
    logic [CHUNK:0] full_tot;
    always_comb begin
        gen_tot  = {1'b0, slice_a} + {1'b0, slice_b};
        full_tot = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, slice_cin};
        slice_g  = gen_tot[CHUNK];
        slice_p  = &(slice_a ^ slice_b);
        slice_s  = full_tot[CHUNK-1:0];
    end

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic ci);
        logic [WIDTH:0] full;
        logic v;
        full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        v = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {v, full};
    endfunction

    // Carry into chunk k: what the low k chunks of x+y+ci carry out.
    function automatic logic carry_into_chunk(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic ci, input int k);
        longint unsigned m;
        longint unsigned lo;
        m  = (64'd1 << (k * CHUNK)) - 64'd1;
        lo = (longint'(x) & m) + (longint'(y) & m) + longint'(ci);
        return 1'((lo >> (k * CHUNK)) & 64'd1);
    endfunction

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One add: accept, per-chunk slice checks, result, optional stall, then the result handshake.
    // poke drives a bogus operand set with in_valid during RUN. abort_at >= 0 resets on that RUN cycle.
    task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tcin,
                           input int stall, input bit poke, input int abort_at, input bit early_ready);
        int waited;
        logic [EW-1:0] e;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("in_ready_wait", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        c_in     = tcin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = early_ready;
        exp_q.push_back(ref_add(ta, tb_v, tcin));
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq("abort_in_ready", 32'(in_ready), 32'd1);
                check_eq("abort_out_valid", 32'(out_valid), 32'd0);
                check_eq("abort_sum", 32'(sum), 32'd0);
                void'(exp_q.pop_back());
                @(negedge clk);
                rst = 1'b0;
                repeat (N + 3) begin
                    @(negedge clk);
                    check_eq("abort_no_result", 32'(out_valid), 32'd0);
                end
                out_ready = 1'b0;
                return;
            end
            check_eq("slice_a", 32'(slice_a), 32'(ta[k*CHUNK +: CHUNK]));
            check_eq("slice_b", 32'(slice_b), 32'(tb_v[k*CHUNK +: CHUNK]));
            check_eq("slice_cin", 32'(slice_cin), 32'(carry_into_chunk(ta, tb_v, tcin, k)));
            check_eq("run_out_valid", 32'(out_valid), 32'd0);
            check_eq("run_in_ready", 32'(in_ready), 32'd0);
            if (poke && k == 0) begin
                a        = 16'hAAAA;
                b        = 16'h5555;
                in_valid = 1'b1;
            end
            if (poke && k == N - 1) in_valid = 1'b0;
        end
        // out_valid is seen by the consumer at the (N+1)th rising edge after the accept.
        @(negedge clk);
        check_eq("latency_out_valid", 32'(out_valid), 32'd1);
        check_eq("done_in_ready", 32'(in_ready), 32'd0);
        e = exp_q.pop_front();
        check_eq("sum", 32'(sum), 32'(e[WIDTH-1:0]));
        check_eq("c_out", 32'(c_out), 32'(e[WIDTH]));
`ifdef CLA_SEQ_OVF_EN
        check_eq("ovf", 32'(ovf), 32'(e[WIDTH+1]));
`endif
        if (!early_ready) begin
            repeat (stall) begin
                @(negedge clk);
                check_eq("stall_out_valid", 32'(out_valid), 32'd1);
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stall_sum", 32'(sum), 32'(e[WIDTH-1:0]));
                check_eq("stall_c_out", 32'(c_out), 32'(e[WIDTH]));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_out_valid", 32'(out_valid), 32'd0);
        check_eq("post_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus and report ----------------
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_c_out", 32'(c_out), 32'd0);
        check_eq("rst_slice_a", 32'(slice_a), 32'd0);
        check_eq("rst_slice_b", 32'(slice_b), 32'd0);
        check_eq("rst_slice_cin", 32'(slice_cin), 32'd0);
`ifdef CLA_SEQ_OVF_EN
        check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        run_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0, -1, 1'b0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, -1, 1'b0);
        run_add(16'h0000, 16'h0000, 1'b1, 10, 1'b0, -1, 1'b0);
        run_add(16'h1111, 16'h2222, 1'b0, 2, 1'b1, -1, 1'b0);
        run_add(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, 1, 1'b0);
        run_add(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, -1, 1'b0);
        run_add(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, -1, 1'b0);
        run_add(16'h8000, 16'h8000, 1'b0, 0, 1'b0, -1, 1'b0);
        run_add(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0, -1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_add(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
        end

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound the run so it can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
